// File: rtl/rob_complete_arb.sv
// rob_complete_arb
//   Collects completions from NUM_SRC execution units and funnels them into
//   the ROB's single mark-ready write port, at most one per cycle.
//
//   Each source owns a small FIFO of {exception, idx}. A round-robin arbiter
//   pops one non-empty FIFO per edge, starting its search at rr_ptr. The
//   popped entry appears on mark_ready_* in the cycle after the pop edge.
//
// Ports
//   clk, reset       : clock; synchronous active-high reset
//   src_valid/idx/   : per-source completion request, ROB index and
//   src_exception      exception flag
//   src_ready        : per-source accept (FIFO not full and no flush)
//   mark_ready_en/   : registered ROB write port; idx holds when idle
//   idx/val/exception
//   flush_en         : discards every buffered completion
//   pending_cnt      : total completions currently buffered

package core_pkg;
    localparam int ROB_ENTRIES = 32;
endpackage

module rob_complete_arb #(
    parameter int NUM_SRC    = 4,
    parameter int IDX_BITS   = $clog2(core_pkg::ROB_ENTRIES),
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_SRC-1:0]                         src_valid,
    input  logic [NUM_SRC-1:0][IDX_BITS-1:0]           src_idx,
    input  logic [NUM_SRC-1:0]                         src_exception,
    output logic [NUM_SRC-1:0]                         src_ready,
    output logic                                       mark_ready_en,
    output logic [IDX_BITS-1:0]                        mark_ready_idx,
    output logic                                       mark_ready_val,
    output logic                                       mark_exception,
    input  logic                                       flush_en,
    output logic [$clog2(NUM_SRC*FIFO_DEPTH+1)-1:0]    pending_cnt
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int RR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int PEND_W = $clog2(NUM_SRC * FIFO_DEPTH + 1);

    typedef struct packed {
        logic                exc;
        logic [IDX_BITS-1:0] idx;
    } entry_t;

    entry_t            mem    [NUM_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NUM_SRC];
    logic [PTR_W-1:0]  rd_ptr [NUM_SRC];
    logic [CNT_W-1:0]  count  [NUM_SRC];
    logic [RR_W-1:0]   rr_ptr;
    logic [RR_W-1:0]   rr_next;

    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic               grant_valid;
    logic [RR_W-1:0]    grant_idx;
    entry_t             head;

    // Ready looks only at the registered count, so a pop from a full FIFO
    // frees the slot for the next cycle, not this one.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = (count[i] < CNT_W'(FIFO_DEPTH)) && !flush_en;
        end
    end

    assign push = src_valid & src_ready;

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_SRC.
    // NOTE: every combinational output gets a default before any branch so
    // that no path leaves it unassigned and a latch is never inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!grant_valid && count[(int'(rr_ptr) + k) % NUM_SRC] != '0) begin
                grant_valid = 1'b1;
                grant_idx   = RR_W'((int'(rr_ptr) + k) % NUM_SRC);
            end
        end
        if (flush_en) begin
            grant_valid = 1'b0;
        end
    end

    always_comb begin
        pop = '0;
        if (grant_valid) begin
            pop[grant_idx] = 1'b1;
        end
    end

    assign head    = mem[grant_idx][rd_ptr[grant_idx]];
    assign rr_next = (grant_idx == RR_W'(NUM_SRC - 1)) ? '0 : grant_idx + RR_W'(1);

    always_comb begin
        pending_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pending_cnt = pending_cnt + PEND_W'(count[i]);
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read while
    // its FIFO count says it was written, so clearing the data buys nothing.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= entry_t'({src_exception[i], src_idx[i]});
            end
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values and the update order inside the block is moot.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr         <= '0;
            mark_ready_en  <= 1'b0;
            mark_ready_val <= 1'b0;
            mark_exception <= 1'b0;
            mark_ready_idx <= '0;
        end else if (flush_en) begin
            // Flush drops everything buffered; the index output is left alone.
            for (int i = 0; i < NUM_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr         <= '0;
            mark_ready_en  <= 1'b0;
            mark_ready_val <= 1'b0;
            mark_exception <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
            if (grant_valid) begin
                rr_ptr         <= rr_next;
                mark_ready_en  <= 1'b1;
                mark_ready_val <= 1'b1;
                mark_exception <= head.exc;
                mark_ready_idx <= head.idx;
            end else begin
                mark_ready_en  <= 1'b0;
                mark_ready_val <= 1'b0;
                mark_exception <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rob_complete_arb.sv
// Testbench for rob_complete_arb: directed scenarios followed by random
// traffic, all checked every cycle against a queue-based reference model.

module tb_rob_complete_arb;

    localparam int NUM_SRC  = 4;
    localparam int IDX_BITS = 5;
    localparam int DEPTH    = 2;
    localparam int PEND_W   = $clog2(NUM_SRC * DEPTH + 1);

    logic                             clk = 1'b0;
    logic                             reset;
    logic [NUM_SRC-1:0]               src_valid;
    logic [NUM_SRC-1:0][IDX_BITS-1:0] src_idx;
    logic [NUM_SRC-1:0]               src_exception;
    logic [NUM_SRC-1:0]               src_ready;
    logic                             mark_ready_en;
    logic [IDX_BITS-1:0]              mark_ready_idx;
    logic                             mark_ready_val;
    logic                             mark_exception;
    logic                             flush_en;
    logic [PEND_W-1:0]                pending_cnt;

    always #5 clk = ~clk;

    rob_complete_arb #(
        .NUM_SRC    (NUM_SRC),
        .IDX_BITS   (IDX_BITS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .src_valid      (src_valid),
        .src_idx        (src_idx),
        .src_exception  (src_exception),
        .src_ready      (src_ready),
        .mark_ready_en  (mark_ready_en),
        .mark_ready_idx (mark_ready_idx),
        .mark_ready_val (mark_ready_val),
        .mark_exception (mark_exception),
        .flush_en       (flush_en),
        .pending_cnt    (pending_cnt)
    );

    // Reference model: one queue per source holding (exc << IDX_BITS) | idx.
    int q [NUM_SRC][$];
    int rr;
    int exp_en;
    int exp_exc;
    int exp_idx;

    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: check ready before the edge, advance the model at the edge,
    // check registered outputs just after it, return at the next negedge.
    task automatic cycle();
        int sz [NUM_SRC];
        bit rdy [NUM_SRC];
        int g;
        int e;
        int total;
        #1;
        for (int i = 0; i < NUM_SRC; i++) begin
            sz[i]  = q[i].size();
            rdy[i] = (sz[i] < DEPTH) && !flush_en;
            check($sformatf("src_ready[%0d]", i), src_ready[i], rdy[i]);
        end
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) q[i].delete();
            rr = 0; exp_en = 0; exp_exc = 0; exp_idx = 0;
        end else if (flush_en) begin
            for (int i = 0; i < NUM_SRC; i++) q[i].delete();
            rr = 0; exp_en = 0; exp_exc = 0;
        end else begin
            g = -1;
            for (int k = 0; k < NUM_SRC; k++) begin
                if (g < 0 && sz[(rr + k) % NUM_SRC] > 0) g = (rr + k) % NUM_SRC;
            end
            if (g >= 0) begin
                e       = q[g].pop_front();
                exp_en  = 1;
                exp_idx = e & ((1 << IDX_BITS) - 1);
                exp_exc = e >> IDX_BITS;
                rr      = (g + 1) % NUM_SRC;
            end else begin
                exp_en  = 0;
                exp_exc = 0;
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_valid[i] && rdy[i])
                    q[i].push_back((int'(src_exception[i]) << IDX_BITS) | int'(src_idx[i]));
            end
        end
        #1;
        total = 0;
        for (int i = 0; i < NUM_SRC; i++) total += q[i].size();
        check("mark_ready_en",  mark_ready_en,  exp_en);
        check("mark_ready_val", mark_ready_val, exp_en);
        check("mark_exception", mark_exception, exp_exc);
        check("mark_ready_idx", mark_ready_idx, exp_idx);
        check("pending_cnt",    pending_cnt,    total);
        @(negedge clk);
    endtask

    initial begin
        int k1;
        bit acc;
        bit saw_full;

        n_tests = 0; n_fail = 0;
        rr = 0; exp_en = 0; exp_exc = 0; exp_idx = 0;
        reset = 1'b1; flush_en = 1'b0;
        src_valid = '0; src_idx = '0; src_exception = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cycle();
        reset = 1'b0;

        // Single source: idx 5 pushed, visible one edge later for one cycle.
        src_valid = 4'b0001; src_idx[0] = 5'd5;
        cycle();
        check("single_pend1", pending_cnt, 1);
        src_valid = '0;
        cycle();
        check("single_en", mark_ready_en, 1);
        check("single_idx", mark_ready_idx, 5);
        check("single_pend0", pending_cnt, 0);
        cycle();
        check("single_en_off", mark_ready_en, 0);
        check("single_idx_hold", mark_ready_idx, 5);

        // Round-robin from rr_ptr = 0 after a flush.
        flush_en = 1'b1; cycle(); flush_en = 1'b0;
        src_valid = '1;
        for (int i = 0; i < NUM_SRC; i++) src_idx[i] = IDX_BITS'(10 + i);
        cycle();
        src_valid = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cycle();
            check($sformatf("rr_out%0d", k), mark_ready_idx, 10 + k);
        end
        src_valid = '1; cycle(); src_valid = '0;
        cycle();
        check("rr_wrap", mark_ready_idx, 10);
        repeat (3) cycle();

        // Exception flag travels with its index for one cycle.
        src_valid = 4'b0100; src_idx[2] = 5'd7; src_exception[2] = 1'b1;
        cycle();
        src_valid = '0; src_exception = '0;
        cycle();
        check("exc_flag", mark_exception, 1);
        check("exc_idx", mark_ready_idx, 7);
        cycle();
        check("exc_flag_off", mark_exception, 0);

        // Backpressure: src1 holds 20,21,22 while src0 competes.
        flush_en = 1'b1; cycle(); flush_en = 1'b0;
        k1 = 0; saw_full = 1'b0;
        for (int c = 0; c < 30 && k1 < 3; c++) begin
            src_valid    = 4'b0011;
            src_idx[0]   = IDX_BITS'(c);
            src_idx[1]   = IDX_BITS'(20 + k1);
            acc          = q[1].size() < DEPTH;
            if (!acc) saw_full = 1'b1;
            cycle();
            if (acc) k1++;
        end
        src_valid = '0;
        check("bp_saw_full", saw_full, 1);
        check("bp_pushed", k1, 3);
        repeat (8) cycle();

        // Flush with five buffered completions while src3 tries to push 30.
        for (int i = 0; i < NUM_SRC; i++) src_idx[i] = IDX_BITS'(i + 1);
        src_valid = '1; cycle();
        src_valid = 4'b0011; cycle();
        check("flush_pre_pend", pending_cnt, 5);
        flush_en = 1'b1; src_valid = 4'b1000; src_idx[3] = 5'd30;
        cycle();
        check("flush_pend", pending_cnt, 0);
        check("flush_en_off", mark_ready_en, 0);
        flush_en = 1'b0; src_valid = '0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check($sformatf("flush_idle%0d", k), mark_ready_en, 0);
        end

        // Reset in the middle of heavy traffic.
        src_valid = '1;
        repeat (4) cycle();
        check("busy_pend", pending_cnt, 7);
        reset = 1'b1;
        cycle();
        check("rst_en", mark_ready_en, 0);
        check("rst_idx", mark_ready_idx, 0);
        check("rst_pend", pending_cnt, 0);
        reset = 1'b0;
        src_valid = 4'b0001; src_idx[0] = 5'd1;
        cycle();
        src_valid = '0;
        cycle();
        check("post_rst_en", mark_ready_en, 1);
        check("post_rst_idx", mark_ready_idx, 1);

        // Random traffic with occasional flush and reset.
        for (int c = 0; c < 600; c++) begin
            src_valid     = NUM_SRC'($urandom);
            src_exception = NUM_SRC'($urandom);
            for (int i = 0; i < NUM_SRC; i++) src_idx[i] = IDX_BITS'($urandom);
            flush_en = ($urandom_range(0, 31) == 0);
            reset    = ($urandom_range(0, 63) == 0);
            cycle();
        end
        reset = 1'b0; flush_en = 1'b0; src_valid = '0;
        repeat (10) cycle();
        check("drain_pend", pending_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_complete_arb.md
ROB_COMPLETE_ARB -- requirements
Module: rob_complete_arb

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_SRC, 4, number of completing execution units.
- IDX_BITS, $clog2(core_pkg::ROB_ENTRIES), ROB index width.
- FIFO_DEPTH, 2, per-source completion buffer depth (power of two, >=2).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on rising edge.
- reset, in, 1, synchronous active-high reset.
- src_valid, in, NUM_SRC, completion request per source.
- src_idx, in, NUM_SRC x IDX_BITS, ROB index completed by each source.
- src_exception, in, NUM_SRC, exception flag for each completion.
- src_ready, out, NUM_SRC, per-source accept.
- mark_ready_en, out, 1, drives ROB single mark-ready port.
- mark_ready_idx, out, IDX_BITS, ROB entry to mark.
- mark_ready_val, out, 1, ready value to write.
- mark_exception, out, 1, exception flag to write.
- flush_en, in, 1, pipeline flush; discards all buffered completions.
- pending_cnt, out, $clog2(NUM_SRC*FIFO_DEPTH+1), total buffered completions.

Function
REQ-003 Each source SHALL own a FIFO of FIFO_DEPTH entries holding {idx, exception}, with wrapping read/write pointers and an occupancy count.
REQ-004 src_ready[i] SHALL be 1 iff FIFO i count < FIFO_DEPTH and flush_en == 0; it is combinational and independent of src_valid[i] and of same-cycle pops.
REQ-005 A push SHALL occur at a rising edge when src_valid[i] && src_ready[i]; src_valid with src_ready == 0 is ignored and not retained.
REQ-006 At each rising edge without flush, the arbiter SHALL select one non-empty FIFO by round-robin, searching from rr_ptr upward modulo NUM_SRC, and pop its head.
REQ-007 On a grant to source g, rr_ptr SHALL become (g+1) mod NUM_SRC; with no grant, rr_ptr SHALL be unchanged.
REQ-008 Outputs SHALL be registered; the popped entry drives mark_ready_en=1, mark_ready_val=1, mark_ready_idx, and mark_exception for exactly the cycle after the pop edge.
REQ-009 With no grant, mark_ready_en, mark_ready_val and mark_exception SHALL be 0, and mark_ready_idx SHALL hold its previous value.
REQ-010 Latency SHALL be a push at edge k, earliest pop at edge k+1, and output valid in cycle k+1..k+2; there is no bypass path.
REQ-011 Throughput SHALL be at most one completion per cycle in total; there is no ordering guarantee between sources, and FIFO order is preserved per source.
REQ-012 Simultaneous push and pop on the same FIFO SHALL update count by net 0 and both pointers SHALL advance.
REQ-013 A pop from a full FIFO SHALL not make src_ready high in the same cycle (per REQ-004); it rises the following cycle.
REQ-014 pending_cnt SHALL equal the sum of all FIFO counts after each edge, with width sufficient for no overflow.
REQ-015 Flush: at an edge with flush_en=1, all FIFO counts and pointers SHALL clear, rr_ptr SHALL go to 0, no pop or push SHALL occur, and mark_ready_en SHALL be 0 in the next cycle.
REQ-016 A completion already presented on mark_ready_* in the flush cycle SHALL still be visible that cycle; the ROB flush handles it.

Reset
REQ-017 At a rising edge with reset=1, all FIFOs SHALL empty, rr_ptr SHALL be 0, and mark_ready_en, mark_ready_val and mark_exception SHALL be 0.
REQ-018 After reset, mark_ready_idx SHALL be 0 and pending_cnt SHALL be 0.
REQ-019 Reset SHALL take priority over flush_en, pushes and pops, including mid-operation with full FIFOs.
REQ-020 src_ready SHALL be all-ones in the first cycle after reset deasserts, provided flush_en=0.

Verification
REQ-021 Single source: src0 pushes idx 5 at edge 1 -> mark_ready_en=1, idx=5, exc=0 after edge 2 only; pending_cnt 1 then 0.
REQ-022 Round-robin: src0..3 push idx 10,11,12,13 at the same edge -> the next four outputs are 10,11,12,13 in order; rr_ptr returns to 0.
REQ-023 Backpressure: src1 holds valid for idx 20,21,22 with arbiter starved (src0 continuously granted first, DEPTH=2) -> src_ready[1]=0 after two pushes; all three emerge in order 20,21,22 with none lost or duplicated.
REQ-024 Exception: src2 pushes idx 7 with exception=1 -> mark_exception=1, mark_ready_idx=7 for one cycle.
REQ-025 Flush: with pending_cnt=5, flush_en for one cycle while src3 pushes idx 30 -> pending_cnt=0, idx 30 is dropped, and mark_ready_en=0 until new pushes.
REQ-026 Reset mid-operation: reset with all FIFOs full -> all outputs at reset values next cycle; then src0 push of idx 1 emerges 2 cycles later.
